ahb_sram_slave: RTL and testbench

AHB-Lite slave with a word-organised SRAM and configurable wait-state insertion. It is the responder end of the AHB interface that the verification environment's driver initiates transfers on. It is the synthesizable DUT answering address/data-phase transfers, with OKAY and two-cycle ERROR responses, little-endian byte-lane writes and full-word reads.

---
 rtl/ahb_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave fronting a word-organised SRAM with optional wait states
// Two-cycle ERROR responses, little-endian byte-lane writes, full-word reads.
module ahb_sram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [1:0]        HTRANS,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LA_W  = IDX_W + 2;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH * 4);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t             state_q, state_d;
    logic               hreadyout_q, hreadyout_d;
    logic               hresp_q, hresp_d;
    logic [DATA_W-1:0]  hrdata_q, hrdata_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               pend_q, pend_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic [LA_W-1:0]    addr_q, addr_d;

    logic [DATA_W-1:0]  mem_q [MEM_DEPTH];

    logic               accept;
    logic               acc_err;
    logic               commit;
    logic [3:0]         wr_be;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_word;
    logic               unused_inputs;

    assign unused_inputs = ^{HBURST, HTRANS[0]};

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] low);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            2'd0:    m = 4'b0001 << low;
            2'd1:    m = low[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    always_comb begin
        accept  = HSEL && HREADY && HTRANS[1] && hreadyout_q;
        acc_err = (HADDR >= ADDR_LIMIT) || (HSIZE > 3'd2) ||
                  ((HSIZE == 3'd1) && HADDR[0]) ||
                  ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
        // hreadyout_q high with a pending transfer marks the completing data-phase cycle
        commit  = pend_q && write_q && hreadyout_q && !HRESET;
        wr_be   = lane_mask(size_q, addr_q[1:0]);
        wr_idx  = addr_q[LA_W-1:2];
    end

    // Read word with the write committing on this same edge folded in
    always_comb begin
        rd_idx  = (state_q == S_WAIT) ? addr_q[LA_W-1:2] : HADDR[LA_W-1:2];
        rd_word = mem_q[rd_idx];
        for (int i = 0; i < 4; i++) begin
            if (commit && wr_be[i] && (wr_idx == rd_idx)) begin
                rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        wait_cnt_d  = wait_cnt_q;
        pend_d      = pend_q;
        write_d     = write_q;
        size_d      = size_q;
        addr_d      = addr_q;
        case (state_q)
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d     = S_IDLE;
                    hreadyout_d = 1'b1;
                    if (!write_q) begin
                        hrdata_d = rd_word;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d     = S_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                pend_d      = 1'b0;
                if (accept) begin
                    addr_d  = HADDR[LA_W-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE[1:0];
                    if (acc_err) begin
                        state_d     = S_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = 1'b1;
                        if (!HWRITE) begin
                            hrdata_d = '0;
                        end
                    end else begin
                        pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d     = S_WAIT;
                            hreadyout_d = 1'b0;
                            wait_cnt_d  = WAIT_INIT;
                        end else if (!HWRITE) begin
                            hrdata_d = rd_word;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            wait_cnt_q  <= 4'd0;
            pend_q      <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_q      <= pend_d;
            write_q     <= write_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave (zero and three wait states)
module tb_ahb_sram_slave;

    typedef struct packed {
        bit        sel;
        bit [1:0]  trans;
        bit [31:0] addr;
        bit        is_wr;
        bit [2:0]  size;
        bit [31:0] wdata;
        bit        chk;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    logic        clk;
    logic        hreset    [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [1:0]  htrans    [2];
    logic [31:0] hwdata    [2];
    logic        hready    [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    int n_checks;
    int n_fail;

    bit [31:0] mem_m  [2][256];
    bit [31:0] exp_rd [2];
    vec_t      vq [$];
    vec_t      tbl0 [20];
    vec_t      tbl1 [4];

    ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HTRANS(htrans[0]),
        .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HTRANS(htrans[1]),
        .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic vec_t wr(input bit [31:0] a, input bit [2:0] s, input bit [31:0] d,
                                input bit chk, input bit e);
        vec_t v;
        v = '0;
        v.sel = 1'b1; v.trans = 2'd2; v.addr = a; v.is_wr = 1'b1; v.size = s;
        v.wdata = d; v.chk = chk; v.exp_err = e;
        return v;
    endfunction

    function automatic vec_t rd(input bit [31:0] a, input bit [2:0] s, input bit chk,
                                input bit [31:0] x, input bit e);
        vec_t v;
        v = '0;
        v.sel = 1'b1; v.trans = 2'd2; v.addr = a; v.size = s;
        v.chk = chk; v.exp_rdata = x; v.exp_err = e;
        return v;
    endfunction

    function automatic vec_t nx(input bit sel, input bit [1:0] tr, input bit [31:0] a, input bit w);
        vec_t v;
        v = '0;
        v.sel = sel; v.trans = tr; v.addr = a; v.is_wr = w; v.size = 3'd2; v.wdata = 32'hFFFF_FFFF;
        return v;
    endfunction

    function automatic vec_t rnd();
        vec_t v;
        int   r;
        v = '0;
        v.sel = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 9);
        v.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
        v.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r = $urandom_range(0, 19);
        if (r == 0) v.addr = 32'h400 + 32'($urandom_range(0, 15));
        else if (r == 1) v.addr = $urandom;
        else begin
            v.addr = 32'($urandom_range(0, 127));
            if (v.size <= 3'd2 && $urandom_range(0, 4) != 0)
                v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
        end
        v.is_wr = 1'($urandom_range(0, 1));
        v.wdata = $urandom;
        return v;
    endfunction

    // Out of range, oversize, or not a multiple of the access size
    function automatic bit is_err(input bit [31:0] a, input bit [2:0] s);
        if (a >= 32'd1024) return 1'b1;
        if (s > 3'd2) return 1'b1;
        return (a & ((32'd1 << s) - 32'd1)) != 32'd0;
    endfunction

    task automatic model_write(input int k, input bit [31:0] a, input bit [2:0] s, input bit [31:0] d);
        int nb;
        int base;
        nb   = 1 << s;
        base = int'(a[1:0]);
        for (int b = base; b < base + nb; b++) mem_m[k][a[9:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic drive_addr(input int k, input vec_t v);
        hsel[k]   = v.sel;
        htrans[k] = v.trans;
        haddr[k]  = v.addr;
        hwrite[k] = v.is_wr;
        hsize[k]  = v.size;
        hburst[k] = 3'($urandom_range(0, 7));
    endtask

    task automatic do_reset(input int k);
        hreset[k] = 1'b1;
        drive_addr(k, nx(1'b0, 2'd0, 32'h0, 1'b0));
        hready[k] = 1'b1;
        hwdata[k] = 32'h0;
        repeat (2) begin @(posedge clk); #1; end
        hreset[k] = 1'b0;
        exp_rd[k] = 32'h0;
        check($sformatf("k%0d reset hreadyout", k), 32'(hreadyout[k]), 32'd1);
        check($sformatf("k%0d reset hresp", k), 32'(hresp[k]), 32'd0);
        check($sformatf("k%0d reset hrdata", k), hrdata[k], 32'h0);
    endtask

    // Pipelined master: next address overlaps the current data phase; HREADY follows the model
    task automatic run_vecs(input int k);
        int   i;
        int   ws;
        int   dp_c;
        bit   dp_v;
        bit   dp_x;
        bit   dp_e;
        bit   exp_rdy;
        bit   exp_resp;
        vec_t dp;
        ws = (k == 0) ? 0 : 3;
        i = 0; dp_v = 1'b0; dp_x = 1'b0; dp_e = 1'b0; dp_c = 0; dp = '0;
        while (i < vq.size() || dp_v) begin
            exp_rdy = 1'b1;
            exp_resp = 1'b0;
            if (dp_v && dp_x) begin
                if (dp_e) begin
                    exp_rdy  = (dp_c == 1);
                    exp_resp = 1'b1;
                    if (!dp.is_wr) exp_rd[k] = 32'h0;
                end else begin
                    exp_rdy = (dp_c == ws);
                    if (exp_rdy && !dp.is_wr) exp_rd[k] = mem_m[k][dp.addr[9:2]];
                end
            end
            check($sformatf("k%0d item%0d c%0d hreadyout", k, i, dp_c), 32'(hreadyout[k]), 32'(exp_rdy));
            check($sformatf("k%0d item%0d c%0d hresp", k, i, dp_c), 32'(hresp[k]), 32'(exp_resp));
            check($sformatf("k%0d item%0d c%0d hrdata", k, i, dp_c), hrdata[k], exp_rd[k]);
            if (dp_v && dp.chk && exp_rdy) begin
                check($sformatf("k%0d tbl addr %h resp", k, dp.addr), 32'(hresp[k]), 32'(dp.exp_err));
                if (!dp.is_wr)
                    check($sformatf("k%0d tbl addr %h rdata", k, dp.addr), hrdata[k], dp.exp_rdata);
            end
            if (i < vq.size()) drive_addr(k, vq[i]);
            else drive_addr(k, nx(1'b0, 2'd0, 32'h0, 1'b0));
            hwdata[k] = (dp_v && dp.is_wr) ? dp.wdata : 32'h0;
            hready[k] = exp_rdy;
            @(posedge clk); #1;
            if (exp_rdy) begin
                if (dp_v && dp_x && !dp_e && dp.is_wr) model_write(k, dp.addr, dp.size, dp.wdata);
                if (i < vq.size()) begin
                    dp   = vq[i];
                    dp_v = 1'b1;
                    dp_x = dp.sel && dp.trans[1];
                    dp_e = dp_x && is_err(dp.addr, dp.size);
                    dp_c = 0;
                    i++;
                end else begin
                    dp_v = 1'b0;
                end
            end else begin
                dp_c++;
                if (dp_c > 20) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL k%0d data phase timeout: got %0d cycles required <= %0d", k, dp_c, ws + 1);
                    dp_v = 1'b0;
                    i = vq.size();
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 2; k++) begin
            hreset[k] = 1'b0; hready[k] = 1'b1; hwdata[k] = 32'h0;
            drive_addr(k, nx(1'b0, 2'd0, 32'h0, 1'b0));
        end

        tbl0 = '{
            wr(32'h10,  3'd2, 32'hDEAD_BEEF, 1, 0),
            rd(32'h10,  3'd2, 1, 32'hDEAD_BEEF, 0),
            wr(32'h10,  3'd2, 32'h1122_3344, 1, 0),
            wr(32'h13,  3'd0, 32'hAA00_0000, 1, 0),
            rd(32'h10,  3'd2, 1, 32'hAA22_3344, 0),
            wr(32'h12,  3'd1, 32'h5566_0000, 1, 0),
            rd(32'h10,  3'd2, 1, 32'h5566_3344, 0),
            rd(32'h402, 3'd2, 1, 32'h0, 1),
            wr(32'h400, 3'd2, 32'hFFFF_FFFF, 1, 1),
            wr(32'h12,  3'd2, 32'h0, 1, 1),
            rd(32'h10,  3'd2, 1, 32'h5566_3344, 0),
            rd(32'h00,  3'd2, 1, 32'hC0DE_0000, 0),
            wr(32'h20,  3'd2, 32'h1234_5678, 1, 0),
            rd(32'h20,  3'd2, 1, 32'h1234_5678, 0),
            nx(1'b1, 2'd0, 32'h20, 1'b0),
            nx(1'b1, 2'd1, 32'h20, 1'b0),
            nx(1'b0, 2'd2, 32'h20, 1'b1),
            rd(32'h20,  3'd2, 1, 32'h1234_5678, 0),
            rd(32'h11,  3'd1, 1, 32'h0, 1),
            rd(32'h10,  3'd3, 1, 32'h0, 1)
        };
        tbl1 = '{
            rd(32'h04,  3'd2, 1, 32'hC0DE_0001, 0),
            wr(32'h08,  3'd2, 32'h0BAD_F00D, 1, 0),
            rd(32'h08,  3'd2, 1, 32'h0BAD_F00D, 0),
            rd(32'h402, 3'd2, 1, 32'h0, 1)
        };

        do_reset(0);
        do_reset(1);

        for (int k = 0; k < 2; k++) begin
            vq.delete();
            for (int j = 0; j < 256; j++) vq.push_back(wr(32'(j * 4), 3'd2, 32'hC0DE_0000 | 32'(j), 0, 0));
            run_vecs(k);
        end

        vq.delete();
        for (int j = 0; j < 20; j++) vq.push_back(tbl0[j]);
        run_vecs(0);

        vq.delete();
        for (int j = 0; j < 4; j++) vq.push_back(tbl1[j]);
        run_vecs(1);

        // Reset lands in the second wait cycle of a write to 0x30
        drive_addr(1, wr(32'h30, 3'd2, 32'h0, 0, 0));
        hready[1] = 1'b1;
        hwdata[1] = 32'h0;
        @(posedge clk); #1;
        check("midrst wait1 hreadyout", 32'(hreadyout[1]), 32'd0);
        drive_addr(1, nx(1'b0, 2'd0, 32'h0, 1'b0));
        hwdata[1] = 32'hBAD0_BAD0;
        hready[1] = 1'b0;
        @(posedge clk); #1;
        check("midrst wait2 hreadyout", 32'(hreadyout[1]), 32'd0);
        hreset[1] = 1'b1;
        @(posedge clk); #1;
        hreset[1] = 1'b0;
        hready[1] = 1'b1;
        exp_rd[1] = 32'h0;
        check("midrst hreadyout", 32'(hreadyout[1]), 32'd1);
        check("midrst hresp", 32'(hresp[1]), 32'd0);
        check("midrst hrdata", hrdata[1], 32'h0);
        vq.delete();
        vq.push_back(rd(32'h30, 3'd2, 1, 32'hC0DE_000C, 0));
        run_vecs(1);

        for (int k = 0; k < 2; k++) begin
            vq.delete();
            for (int j = 0; j < 300; j++) vq.push_back(rnd());
            run_vecs(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
